// File: rtl/mul4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul4_pkg
// Purpose  : Shared types and constants for the 4x4 multiplier display demo:
//            FSM state encoding, seven-segment hex font, blank pattern and
//            the display slots that carry live data.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mul4_pkg;

  // Multiplier sequencer states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Segment pattern for an unlit digit.
  localparam logic [7:0] BLANK = 8'h00;

  // Display slots that carry content; every other slot is blank.
  localparam logic [2:0] DIG_RES_LO = 3'd0;  // result[3:0]
  localparam logic [2:0] DIG_RES_HI = 3'd1;  // result[7:4]
  localparam logic [2:0] DIG_DATA2  = 3'd5;  // live multiplier
  localparam logic [2:0] DIG_DATA1  = 3'd7;  // live multiplicand

  // Hex digit to segment pattern, bit order {dp,g,f,e,d,c,b,a}; dp stays off.
  function automatic logic [7:0] hex2seg(input logic [3:0] nib);
    logic [7:0] seg;
    seg = BLANK;
    case (nib)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      4'hF: seg = 8'h71;
      default: seg = BLANK;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult4_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : mult4_shift_add
// Purpose  : Sequential 4x4 unsigned shift-add multiplier. Watches its
//            operand inputs while idle; whenever they differ from the last
//            captured pair it captures them and spends four cycles
//            accumulating partial products, then publishes the product.
// Ports    : clk   - system clock, rising edge
//            rst_n - synchronous active-low reset
//            a     - multiplicand (4 bits, unsigned)
//            b     - multiplier   (4 bits, unsigned)
//            p     - registered product (8 bits), held between computations
// Revision : 1.0 - initial release
// ============================================================================
module mult4_shift_add
  import mul4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  state_t      r_state;
  logic [3:0]  r_op1;
  logic [3:0]  r_op2;
  logic [7:0]  r_acc;
  logic [1:0]  r_cnt;
  logic [7:0]  r_p;

  logic [7:0]  w_addend;
  logic [7:0]  w_acc_next;

  // Partial product for the current bit of the multiplier. The running sum
  // peaks at 15*15 = 225, so 8 bits never overflow.
  always_comb begin
    w_addend   = r_op2[r_cnt] ? ({4'b0000, r_op1} << r_cnt) : 8'h00;
    w_acc_next = r_acc + w_addend;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op1   <= 4'h0;
      r_op2   <= 4'h0;
      r_acc   <= 8'h00;
      r_cnt   <= 2'd0;
      r_p     <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          // Comparing against the captured pair means unchanged switches
          // never retrigger, and changes made during CALC are picked up
          // here on the first idle cycle.
          if ({a, b} != {r_op1, r_op2}) begin
            r_op1   <= a;
            r_op2   <= b;
            r_acc   <= 8'h00;
            r_cnt   <= 2'd0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_acc <= w_acc_next;
          if (r_cnt == 2'd3) begin
            // Publish the sum including this final step's addend.
            r_p     <= w_acc_next;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign p = r_p;

endmodule
`default_nettype wire

// File: rtl/mul4_seg_top.sv
`default_nettype none
// ============================================================================
// Module   : mul4_seg_top
// Purpose  : Board top for the 4-bit multiplier demo. Multiplies the two
//            switch operands with a shift-add sequencer and scans operands
//            and product across an 8-digit seven-segment display.
// Ports    : clk    - system clock, rising edge
//            rst_n  - synchronous active-low reset
//            data1  - multiplicand switches (4 bits)
//            data2  - multiplier switches (4 bits)
//            an     - one-hot active-high digit enables, bit i = digit i
//            mul    - active-high segments {dp,g,f,e,d,c,b,a}
//            result - registered product data1 x data2
// Params   : SCAN_CYCLES - clocks each digit stays lit (>= 1)
// Revision : 1.0 - initial release
// ============================================================================
module mul4_seg_top
  import mul4_pkg::*;
#(
  parameter int SCAN_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data1,
  input  logic [3:0] data2,
  output logic [7:0] an,
  output logic [7:0] mul,
  output logic [7:0] result
);

  // A divider of one cycle still needs a 1-bit register to stay legal.
  localparam int              DIV_W      = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_CYCLES - 1);

  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_dig;
  logic [7:0]       w_result;
  logic [7:0]       w_seg;

  mult4_shift_add u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (data1),
    .b     (data2),
    .p     (w_result)
  );

  // Digit scan: r_dig advances once every SCAN_CYCLES clocks, wrapping 7->0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= '0;
      r_dig <= 3'd0;
    end else if (r_div == c_div_last) begin
      r_div <= '0;
      r_dig <= r_dig + 3'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Driven only from the registered digit index, so the enable and the
  // segment pattern switch together on the same edge.
  always_comb begin
    w_seg = BLANK;
    case (r_dig)
      DIG_RES_LO: w_seg = hex2seg(w_result[3:0]);
      DIG_RES_HI: w_seg = hex2seg(w_result[7:4]);
      DIG_DATA2:  w_seg = hex2seg(data2);
      DIG_DATA1:  w_seg = hex2seg(data1);
      default:    w_seg = BLANK;
    endcase
  end

  assign an     = 8'b0000_0001 << r_dig;
  assign mul    = w_seg;
  assign result = w_result;

endmodule
`default_nettype wire

// File: tb/tb_mul4_seg_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul4_seg_top
// Purpose  : Self-checking bench for mul4_seg_top: directed and random
//            products with exact latency, display scan and content,
//            mid-computation input change and mid-computation reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul4_seg_top;

  localparam int SCAN = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] data1 = 4'h0;
  logic [3:0] data2 = 4'h0;
  logic [7:0] an;
  logic [7:0] mul;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  logic [7:0] font [16];
  logic [7:0] exp_result = 8'h00;
  logic [3:0] last_a = 4'h0;
  logic [3:0] last_b = 4'h0;

  mul4_seg_top #(.SCAN_CYCLES(SCAN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data1  (data1),
    .data2  (data2),
    .an     (an),
    .mul    (mul),
    .result (result)
  );

  always #5 clk = ~clk;

  // Clocks since the last reset edge; the lit digit is this divided by SCAN.
  always @(posedge clk) begin
    if (!rst_n) edges = 0;
    else        edges = edges + 1;
  end

  function automatic int exp_dig();
    return (edges / SCAN) % 8;
  endfunction

  function automatic logic [7:0] exp_seg(input int d);
    case (d)
      0:       return font[exp_result[3:0]];
      1:       return font[exp_result[7:4]];
      5:       return font[data2];
      7:       return font[data1];
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag);
    check8({tag, "_an"},  an,  8'(1 << exp_dig()));
    check8({tag, "_seg"}, mul, exp_seg(exp_dig()));
  endtask

  task automatic wait_dig(input int d, input string tag);
    for (int i = 0; i < 8 * SCAN && exp_dig() != d; i++) tick();
    check_disp(tag);
  endtask

  // Inputs set before edge k; old result holds through edge k+3, the new
  // product appears after edge k+4.
  task automatic run_mul(input logic [3:0] a, input logic [3:0] b, input string tag);
    data1 = a;
    data2 = b;
    repeat (4) tick();
    check8({tag, "_hold"}, result, exp_result);
    tick();
    exp_result = 8'(int'(a) * int'(b));
    check8({tag, "_prod"}, result, exp_result);
    last_a = a;
    last_b = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ra, rb;
    font = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    // Reset held for two edges.
    rst_n = 1'b0;
    repeat (2) tick();
    check8("rst_result", result, 8'h00);
    check8("rst_an",     an,     8'h01);
    check8("rst_mul",    mul,    8'h3F);
    rst_n = 1'b1;

    // 0x0 equals the reset operands: nothing computes.
    repeat (6) tick();
    check8("zero_idle", result, 8'h00);
    check_disp("zero_disp");

    // 15 x 2 and its digits.
    run_mul(4'hF, 4'h2, "m15x2");
    check8("m15x2_val", result, 8'h1E);
    wait_dig(0, "d0");
    check8("d0_mul", mul, 8'h79);
    wait_dig(1, "d1");
    check8("d1_mul", mul, 8'h06);
    wait_dig(7, "d7");
    check8("d7_mul", mul, 8'h71);
    wait_dig(5, "d5");
    check8("d5_mul", mul, 8'h5B);

    // Same product from two operand pairs, two separate computations.
    run_mul(4'h4, 4'h4, "m4x4");
    run_mul(4'h2, 4'h8, "m2x8");
    check8("m2x8_val", result, 8'h10);
    wait_dig(2, "blank2");
    wait_dig(3, "blank3");
    wait_dig(4, "blank4");
    wait_dig(6, "blank6");

    // Boundaries.
    run_mul(4'hF, 4'hF, "m15x15");
    check8("m15x15_val", result, 8'hE1);
    run_mul(4'hF, 4'h1, "m15x1");
    check8("m15x1_val", result, 8'h0F);
    run_mul(4'h0, 4'h9, "m0x9");
    check8("m0x9_val", result, 8'h00);

    // Operand change two cycles after the load is deferred.
    data1 = 4'h7;
    data2 = 4'h3;
    tick();                       // load, edge k
    tick();                       // k+1
    data2 = 4'h9;
    repeat (2) tick();            // k+2, k+3
    check8("chg_hold", result, exp_result);
    tick();                       // k+4
    exp_result = 8'h15;
    check8("chg_first", result, exp_result);
    repeat (4) tick();            // k+5 reload .. k+8
    check8("chg_hold2", result, exp_result);
    tick();                       // k+9
    exp_result = 8'h3F;
    check8("chg_second", result, exp_result);
    last_a = 4'h7;
    last_b = 4'h9;

    // Random products.
    for (int n = 0; n < 12; n++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      if ({ra, rb} == {last_a, last_b}) rb = rb + 4'h1;
      run_mul(ra, rb, "rand");
      check_disp("rand_disp");
    end

    // Reset in the middle of a computation.
    data1 = 4'hB;
    data2 = 4'h6;
    if ({data1, data2} == {last_a, last_b}) data2 = 4'h5;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    exp_result = 8'h00;
    last_a = 4'h0;
    last_b = 4'h0;
    check8("mid_rst_result", result, 8'h00);
    check8("mid_rst_an",     an,     8'h01);
    check8("mid_rst_mul",    mul,    8'h3F);
    rst_n = 1'b1;
    run_mul(data1, data2, "post_rst");

    // Scan rotation across more than a full frame.
    for (int i = 0; i < 9 * SCAN; i++) begin
      tick();
      check_disp("scan");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul4_seg_top.md
# mul4_seg_top

Board-level top for a 4-bit unsigned multiplier demo. It multiplies two switch-driven 4-bit operands with a sequential shift-add datapath and exposes the 8-bit product. It also time-multiplexes the operands and product onto an 8-digit seven-segment display. It sits directly under the board pin constraints and has no upstream handshake.

## Interface
- `SCAN_CYCLES`, default 1: clocks per display digit; board builds override it, for example 100000.
- `clk`, input, 1 bit: single system clock; all state is updated on its rising edge.
- `rst_n`, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `data1`, input, 4 bits: multiplicand, unsigned, asynchronous switches.
- `data2`, input, 4 bits: multiplier, unsigned, asynchronous switches.
- `an`, output, 8 bits: digit enables, one-hot and active-high; bit i selects digit i.
- `mul`, output, 8 bits: segment pattern, active-high, ordered {dp,g,f,e,d,c,b,a}; dp is always 0.
- `result`, output, 8 bits: registered product data1×data2.

## Operation
- **Operand registers:** `op1` and `op2`, each 4 bits.
  - Accumulator: `acc`, 8 bits.
  - Step counter: `cnt`, 2 bits.
  - FSM states: IDLE and CALC.
- **IDLE:** each cycle, compare {data1,data2} with {op1,op2}.
  - If they differ: load op1←data1, op2←data2, acc←0, cnt←0, and go to CALC.
  - Otherwise stay in IDLE.
- **CALC, step i = cnt:**
  - If op2[i]=1, then acc ← acc + (op1 << i), computed in 8 bits; there is no overflow because the maximum is 15×15=225.
  - When cnt=3: result ← the final accumulator value (including this step's addend) and go to IDLE.
  - Otherwise cnt increments.
- **Input changes during CALC:** ignored. On return to IDLE the mismatch is detected and a new computation starts.
- `result` holds its value between computations and changes only at the end of CALC.
- **Display scan:**
  - `div` counts 0..SCAN_CYCLES−1. The 3-bit digit index `dig` increments, wrapping 7→0, when div wraps.
  - an = 1<<dig.
- **Digit contents:**
  - digit0 = result[3:0]
  - digit1 = result[7:4]
  - digit5 = data2, shown live
  - digit7 = data1, shown live
  - digits 2, 3, 4 and 6 are blank (mul = 8'h00).
- **Hex font, digits 0–F:** 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- `an` and `mul` are combinational from `dig`, `result` and the inputs, and are glitch-free with respect to `dig`.

## Timing
- **Reset (rst_n=0 at an edge):** state=IDLE, op1=op2=0, acc=0, cnt=0, result=8'h00, div=0, dig=0.
  - The outputs therefore read an=8'h01 and mul=8'h3F.
- **Reset mid-CALC:** aborts the computation and forces the values above. If the inputs are non-zero, a fresh computation starts on the first edge after release.
- **Latency:**
  - Inputs stable before edge k, while in IDLE and mismatched: load at edge k.
  - CALC runs on edges k+1..k+4.
  - `result` is valid after edge k+4, i.e. 5 edges from detection.
- **Back-to-back changes:**
  - The earliest a new load can occur is edge k+5.
  - The minimum spacing of result updates is 5 cycles.
- **Inputs equal to the captured operands** (including 0×0 after reset): no computation; result is unchanged.
- **Display:**
  - With SCAN_CYCLES=1, `dig` advances every edge and the full frame is 8 cycles.
  - In general the frame is 8×SCAN_CYCLES cycles.

## Structure
- **Shared package `mul4_pkg`:**
  - state enum {IDLE, CALC}
  - segment font constant/function `hex2seg` (4-bit to 8-bit)
  - BLANK = 8'h00
  - digit-slot constants (0, 1, 5, 7)
- **Sub-module `mult4_shift_add`:** FSM plus datapath; ports clk, rst_n, a, b, p.
- **Top-level scan logic:** the scan counter and digit mux stay in the top.

## Test plan
- **Reset:** hold rst_n=0 for 2 edges -> result=00, an=01, mul=3F.
- **15×2:** apply data1=F, data2=2 -> result=8'h1E exactly 5 edges after detection.
  - digit0 shows mul=79, digit1 shows 06, digit7 shows 71, digit5 shows 5B.
- **Same product from different operands:** 4×4 then 2×8 -> result=10 both times, with two separate 5-cycle computations.
  - Blank digits 2, 3, 4 and 6 show mul=00.
- **Boundaries:**
  - 15×15 -> E1.
  - 15×1 -> 0F.
  - 0×9 -> 00.
- **Change during CALC:** change data2 2 cycles after the load -> the first result is the old product, then the new product 5 cycles after return to IDLE.
- **Mid-CALC reset:** pulse rst_n=0 during CALC -> result=00 immediately, then the correct product 5 edges after release.
  - `an` rotates one-hot 01→02→…→80→01 with one step per SCAN_CYCLES.
